systolic_mm_nxn: RTL

Parametrised N×N output-stationary systolic matrix multiplier, the successor to the fixed 3×3 array. It accepts two N×N matrices over a valid/ready load port and skews the operands internally, so the feeding block needs no diagonal timing. Results drain over a valid/ready output port in row-major order. It sits between the operand buffer and the result writer in the accelerator datapath.

---
 rtl/systolic_mm_nxn.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_mm_nxn.sv
// systolic_mm_nxn: N x N output-stationary systolic matrix multiplier.
// Loads A by columns and B by rows over a valid/ready port, skews the operands
// internally while feeding the PE grid for 3N-2 cycles, then drains C row-major
// over a valid/ready result port.
// Ports:
//   clk, reset (async, active-low)     - clock / reset
//   start                              - job start pulse, honoured only when idle
//   in_valid/in_ready, a_col, b_row    - load beat k: A[:,k] and B[k,:]
//   busy                               - job in progress
//   out_valid/out_ready, out_data,
//   out_row, out_col, out_last         - result beat C[out_row][out_col]
//   done                               - one-cycle pulse after the last beat
// Build option: define SYS_SIGNED_EN for two's-complement operands/results.
module systolic_mm_nxn #(
    parameter  int unsigned N      = 3,
    parameter  int unsigned DATA_W = 2,
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(N),
    localparam int unsigned IDX_W  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_col,
    input  logic [N*DATA_W-1:0]   b_row,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  done
);

    localparam int unsigned T_W    = $clog2(3 * N - 2);
    localparam int unsigned T_LAST = 3 * N - 3;

    typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [T_W-1:0]       t_q, t_d;
    logic [DATA_W-1:0]    a_buf_q [N][N], a_buf_d [N][N];
    logic [DATA_W-1:0]    b_buf_q [N][N], b_buf_d [N][N];
    logic [DATA_W-1:0]    a_pipe_q [N][N-1], a_pipe_d [N][N-1];
    logic [DATA_W-1:0]    b_pipe_q [N-1][N], b_pipe_d [N-1][N];
    logic [ACC_W-1:0]     acc_q [N][N], acc_d [N][N];
    logic                 in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [ACC_W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0]     out_row_q, out_row_d, out_col_q, out_col_d;
    logic [DATA_W-1:0]    a_edge [N], b_edge [N];
    logic [DATA_W-1:0]    a_in [N][N], b_in [N][N];

    // One PE product, extended to the accumulator width.
    function automatic logic [ACC_W-1:0] product(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef SYS_SIGNED_EN
        logic [ACC_W-1:0] a_x, b_x;
        a_x = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
        b_x = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
        // Low ACC_W bits of the wide product equal the signed product.
        return a_x * b_x;
`else
        return ACC_W'(a) * ACC_W'(b);
`endif
    endfunction

    // Diagonal skew: row i sees A[i][t-i], column j sees B[t-j][j], else 0.
    always_comb begin : edge_feed
        for (int i = 0; i < N; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(t_q) == i + k) begin
                    a_edge[i] = a_buf_q[i][k];
                    b_edge[i] = b_buf_q[k][i];
                end
            end
        end
    end

    // Operand seen by each PE: edge feed or neighbour's registered operand.
    always_comb begin : pe_inputs
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_edge[i];
            b_in[0][i] = b_edge[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_pipe_q[i][j-1];
                b_in[j][i] = b_pipe_q[j-1][i];
            end
        end
    end

    // Next-state, datapath and output-register logic.
    always_comb begin : next_state
        logic [IDX_W-1:0] row_n, col_n;
        state_d     = state_q;
        k_d         = k_q;
        t_d         = t_q;
        a_buf_d     = a_buf_q;
        b_buf_d     = b_buf_q;
        a_pipe_d    = a_pipe_q;
        b_pipe_d    = b_pipe_q;
        acc_d       = acc_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        row_n       = out_row_q;
        col_n       = out_col_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            acc_d[i][j] = '0;
                        end
                        for (int j = 0; j < N - 1; j++) begin
                            a_pipe_d[i][j] = '0;
                            b_pipe_d[j][i] = '0;
                        end
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        a_buf_d[i][k_q] = a_col[i*DATA_W +: DATA_W];
                        b_buf_d[k_q][i] = b_row[i*DATA_W +: DATA_W];
                    end
                    if (k_q == IDX_W'(N - 1)) begin
                        state_d = FEED;
                        t_d     = '0;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            FEED: begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc_d[i][j] = acc_q[i][j] + product(a_in[i][j], b_in[i][j]);
                    end
                    for (int j = 0; j < N - 1; j++) begin
                        a_pipe_d[i][j] = a_in[i][j];
                        b_pipe_d[j][i] = b_in[j][i];
                    end
                end
                if (t_q == T_W'(T_LAST)) begin
                    // C[0][0] settled long before the last PE finishes.
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_row_d   = '0;
                    out_col_d   = '0;
                    out_last_d  = 1'b0;
                    out_data_d  = acc_q[0][0];
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_row_d   = '0;
                        out_col_d   = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        if (out_col_q == IDX_W'(N - 1)) begin
                            col_n = '0;
                            row_n = out_row_q + IDX_W'(1);
                        end else begin
                            col_n = out_col_q + IDX_W'(1);
                        end
                        out_row_d  = row_n;
                        out_col_d  = col_n;
                        out_data_d = acc_q[row_n][col_n];
                        out_last_d = (row_n == IDX_W'(N - 1)) && (col_n == IDX_W'(N - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            t_q         <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf_q[i][j] <= '0;
                    b_buf_q[i][j] <= '0;
                    acc_q[i][j]   <= '0;
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_pipe_q[i][j] <= '0;
                    b_pipe_q[j][i] <= '0;
                end
            end
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            a_buf_q     <= a_buf_d;
            b_buf_q     <= b_buf_d;
            a_pipe_q    <= a_pipe_d;
            b_pipe_q    <= b_pipe_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule
